// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank.
package spi_reg_pkg;

  localparam int unsigned ADDR_W = 8;

  typedef enum logic {ST_ADDR, ST_DATA} spi_state_t;

  function automatic int unsigned bytes_per_ch(input int unsigned width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// LSB-first byte shifter: bit slot counter, receive register, transmit bit mux
// and the idle-timeout counter that terminates a frame.
module spi_byte_shifter #(
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_din,
  input  logic       i_tx_en,
  input  logic [7:0] i_tx_byte,
  output logic       o_dout,
  output logic       o_byte_done,
  output logic [7:0] o_rx_byte,
  output logic       o_timeout,
  output logic       o_active
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [IW-1:0] r_idle_cnt;
  logic          r_active;
  logic [7:0]    w_byte;

  // Completed byte includes the bit arriving on this edge.
  always_comb begin
    w_byte            = r_shreg;
    w_byte[r_bit_cnt] = i_din;
  end

  assign o_rx_byte   = w_byte;
  assign o_byte_done = i_en && (r_bit_cnt == 3'd7);
  assign o_timeout   = !i_en && (r_idle_cnt == IW'(IDLE_CYCLES - 1));
  assign o_dout      = i_tx_en & i_tx_byte[r_bit_cnt];
  assign o_active    = r_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_idle_cnt <= '0;
      r_active   <= 1'b0;
    end else if (i_en) begin
      r_shreg    <= w_byte;
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      r_idle_cnt <= '0;
      r_active   <= 1'b1;
    end else begin
      if (r_idle_cnt != IW'(IDLE_CYCLES))
        r_idle_cnt <= r_idle_cnt + IW'(1);
      if (o_timeout) begin
        r_bit_cnt <= '0;
        r_active  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Serial register bank: address byte then auto-incrementing RW/RO byte access,
// with per-frame channel snapshot and zero reads for unmapped addresses.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_WIDTH    = 50,
  parameter int unsigned NUM_RW      = 3,
  parameter int unsigned RW_BASE     = 1,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       serial_en,
  input  logic                       serial_in,
  output logic                       serial_out,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  output logic [NUM_RW*8-1:0]        rw_regs,
  output logic [NUM_RW-1:0]          wr_strobe,
  output logic                       frame_active
);

  localparam int unsigned BPC     = bytes_per_ch(CH_WIDTH);
  localparam int unsigned RO_BASE = RW_BASE + NUM_RW;
  localparam int unsigned RO_END  = RO_BASE + NUM_CH * BPC;
  localparam int unsigned PADW    = NUM_CH * BPC * 8;

  if (RO_END > 256) begin : g_map_check
    $error("spi_reg_bank: channel area exceeds 8-bit address space");
  end

  spi_state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]         r_addr;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic [NUM_CH*CH_WIDTH-1:0] r_snapshot;
  logic [7:0]                r_tx_byte;
  logic [NUM_RW*8-1:0]       r_rw_regs;
  logic [NUM_RW-1:0]         r_wr_strobe;
  logic                      w_byte_done;
  logic                      w_timeout;
  logic [7:0]                w_rx_byte;
  logic [7:0]                w_rd_addr;
  logic [7:0]                w_rd_next;

  function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a,
                                         input logic [NUM_CH*CH_WIDTH-1:0] bus,
                                         input logic [NUM_RW*8-1:0] regs);
    int unsigned ai;
    logic [PADW-1:0] pad;
    logic [7:0] v;
    ai  = 32'(a);
    pad = '0;
    v   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      pad[k*BPC*8 +: CH_WIDTH] = bus[k*CH_WIDTH +: CH_WIDTH];
    if (ai >= RW_BASE && ai < RO_BASE)
      v = regs[(ai - RW_BASE)*8 +: 8];
    else if (ai >= RO_BASE && ai < RO_END)
      v = pad[(ai - RO_BASE)*8 +: 8];
    return v;
  endfunction

  spi_byte_shifter #(.IDLE_CYCLES(IDLE_CYCLES)) u_shifter (
    .i_clk       (sclk),
    .i_rst       (rst),
    .i_en        (serial_en),
    .i_din       (serial_in),
    .i_tx_en     (r_state == ST_DATA),
    .i_tx_byte   (r_tx_byte),
    .o_dout      (serial_out),
    .o_byte_done (w_byte_done),
    .o_rx_byte   (w_rx_byte),
    .o_timeout   (w_timeout),
    .o_active    (frame_active)
  );

  assign w_addr_nxt = r_addr + ADDR_W'(1);
  // Address byte reads live channel data; later bytes read the frame snapshot.
  assign w_rd_addr  = rd_byte(w_rx_byte, ch_data, r_rw_regs);
  assign w_rd_next  = rd_byte(w_addr_nxt, r_snapshot, r_rw_regs);

  always_ff @(posedge sclk) begin
    if (rst) r_state <= ST_ADDR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout)        w_state_nxt = ST_ADDR;
    else if (w_byte_done) w_state_nxt = ST_DATA;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_addr      <= '0;
      r_snapshot  <= '0;
      r_tx_byte   <= '0;
      r_rw_regs   <= '0;
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (w_byte_done) begin
        if (r_state == ST_ADDR) begin
          r_addr     <= w_rx_byte;
          r_snapshot <= ch_data;
          r_tx_byte  <= w_rd_addr;
        end else begin
          for (int unsigned r = 0; r < NUM_RW; r++) begin
            if (32'(r_addr) == RW_BASE + r) begin
              r_rw_regs[r*8 +: 8] <= w_rx_byte;
              r_wr_strobe[r]      <= 1'b1;
            end
          end
          r_addr    <= w_addr_nxt;
          r_tx_byte <= w_rd_next;
        end
      end
    end
  end

  assign rw_regs   = r_rw_regs;
  assign wr_strobe = r_wr_strobe;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank with default parameters.
module tb_spi_reg_bank;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_en = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_out;
  logic [399:0] ch_data = '0;
  logic [23:0]  rw_regs;
  logic [2:0]   wr_strobe;
  logic         frame_active;

  int total = 0;
  int bad = 0;
  int scnt [3] = '{0, 0, 0};

  spi_reg_bank #(.NUM_CH(8), .CH_WIDTH(50), .NUM_RW(3), .RW_BASE(1), .IDLE_CYCLES(8)) dut (
    .sclk         (sclk),
    .rst          (rst),
    .serial_en    (serial_en),
    .serial_in    (serial_in),
    .serial_out   (serial_out),
    .ch_data      (ch_data),
    .rw_regs      (rw_regs),
    .wr_strobe    (wr_strobe),
    .frame_active (frame_active)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) begin
    #2;
    for (int r = 0; r < 3; r++)
      if (wr_strobe[r] === 1'b1) scnt[r]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output logic [7:0] rd);
    for (int i = 0; i < 8; i++) begin
      @(negedge sclk);
      serial_en = 1'b1;
      serial_in = d[i];
      #1 rd[i] = serial_out;
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      serial_en = 1'b1;
      serial_in = d[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sclk);
      serial_en = 1'b0;
      serial_in = 1'b0;
    end
  endtask

  logic [7:0] rd;
  logic [7:0] exp_ch [14];
  int base [3];

  initial begin
    exp_ch = '{8'hD3, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h02,
               8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h03};

    repeat (3) @(negedge sclk);
    chk("reset_rw_regs", 64'(rw_regs), 64'h0);
    chk("reset_strobe", 64'(wr_strobe), 64'h0);
    chk("reset_sout", 64'(serial_out), 64'h0);
    chk("reset_active", 64'(frame_active), 64'h0);
    rst = 1'b0;

    // write burst
    send_byte(8'h01, rd);
    chk("addr_sout_zero", 64'(rd), 64'h0);
    send_byte(8'h10, rd);
    chk("wr_old_reg0", 64'(rd), 64'h0);
    send_byte(8'h20, rd);
    send_byte(8'h30, rd);
    idle(1);
    chk("wr_rw_regs", 64'(rw_regs), 64'h302010);
    chk("wr_active", 64'(frame_active), 64'h1);
    chk("wr_strobe0", 64'(scnt[0]), 64'd1);
    chk("wr_strobe1", 64'(scnt[1]), 64'd1);
    chk("wr_strobe2", 64'(scnt[2]), 64'd1);
    idle(8);
    chk("idle_active_low", 64'(frame_active), 64'h0);

    // read-back with identical rewrite
    send_byte(8'h01, rd);
    send_byte(8'h10, rd);
    chk("rb_reg0", 64'(rd), 64'h10);
    send_byte(8'h20, rd);
    chk("rb_reg1", 64'(rd), 64'h20);
    send_byte(8'h30, rd);
    chk("rb_reg2", 64'(rd), 64'h30);
    idle(9);
    chk("rb_rw_regs", 64'(rw_regs), 64'h302010);
    chk("rb_strobe1", 64'(scnt[1]), 64'd2);

    // channel reads across ch0 into ch1
    ch_data[0 +: 50]  = 50'h2D2D2D2D2D2D3;
    ch_data[50 +: 50] = 50'h3010203040506;
    send_byte(8'h04, rd);
    for (int i = 0; i < 14; i++) begin
      send_byte(8'h00, rd);
      chk($sformatf("ch_byte%0d", i), 64'(rd), 64'(exp_ch[i]));
    end
    idle(9);

    // snapshot holds across a mid-frame change
    send_byte(8'h04, rd);
    @(posedge sclk);
    #1 ch_data[0 +: 50] = '0;
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h00, rd);
      chk($sformatf("snap_byte%0d", i), 64'(rd), 64'(exp_ch[i]));
    end
    idle(9);
    send_byte(8'h04, rd);
    send_byte(8'h00, rd);
    chk("snap_new_frame", 64'(rd), 64'h0);
    idle(9);

    // unmapped region
    for (int r = 0; r < 3; r++) base[r] = scnt[r];
    send_byte(8'h3C, rd);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hEE, rd);
      chk($sformatf("unmapped%0d", i), 64'(rd), 64'h0);
    end
    idle(9);
    chk("unmapped_rw", 64'(rw_regs), 64'h302010);
    chk("unmapped_strobes", 64'((scnt[0] - base[0]) + (scnt[1] - base[1]) + (scnt[2] - base[2])), 64'd0);

    // pointer wrap 0xFF -> 0x00 -> 0x01
    for (int r = 0; r < 3; r++) base[r] = scnt[r];
    send_byte(8'hFF, rd);
    send_byte(8'hAA, rd);
    chk("wrap_ff", 64'(rd), 64'h0);
    send_byte(8'hBB, rd);
    chk("wrap_00", 64'(rd), 64'h0);
    send_byte(8'h10, rd);
    chk("wrap_01", 64'(rd), 64'h10);
    send_byte(8'h20, rd);
    chk("wrap_02", 64'(rd), 64'h20);
    idle(9);
    chk("wrap_rw", 64'(rw_regs), 64'h302010);
    chk("wrap_strobe0", 64'(scnt[0] - base[0]), 64'd1);
    chk("wrap_strobe2", 64'(scnt[2] - base[2]), 64'd0);

    // reset in the middle of an address byte
    send_bits(8'hA5, 3);
    @(negedge sclk);
    serial_en = 1'b0;
    rst = 1'b1;
    @(negedge sclk);
    chk("midrst_rw", 64'(rw_regs), 64'h0);
    chk("midrst_active", 64'(frame_active), 64'h0);
    chk("midrst_sout", 64'(serial_out), 64'h0);
    rst = 1'b0;
    send_byte(8'h02, rd);
    send_byte(8'h55, rd);
    chk("midrst_read", 64'(rd), 64'h0);
    idle(9);
    chk("midrst_write", 64'(rw_regs), 64'h005500);

    // idle timeout discards a partial data byte
    for (int r = 0; r < 3; r++) base[r] = scnt[r];
    send_byte(8'h03, rd);
    send_bits(8'hFF, 5);
    idle(9);
    chk("partial_rw", 64'(rw_regs), 64'h005500);
    chk("partial_strobe2", 64'(scnt[2] - base[2]), 64'd0);
    send_byte(8'h03, rd);
    send_byte(8'h77, rd);
    chk("partial_read", 64'(rd), 64'h0);
    idle(1);
    chk("partial_after", 64'(rw_regs), 64'h775500);
    idle(9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
